// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM state encoding and the default address/data
// widths used by the initiator, the address decoder and the peripherals.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding STB/ACK bus master. Takes one CPU load/store request,
// strobes the peripheral bus until ACK or timeout, then holds the response
// until the CPU takes it.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // CPU request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // CPU response port
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  // Peripheral bus
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              ACK_I
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value on the last permitted STB cycle; no ACK there means timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bus_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stb_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Transaction FSM with registered bus/response outputs and inline timeout counter.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            adr_q   <= req_addr;
            wdat_q  <= req_wdata;
            cnt_q   <= '0;
            stb_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (ACK_I) begin
            rdata_q <= we_q ? '0 : DAT_I;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            stb_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          stb_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode the state register directly; req_ready is also
  // held low for the whole time reset is asserted.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign STB_O      = stb_q;
  assign WE_O       = we_q;
  assign ADR_O      = adr_q;
  assign DAT_O      = wdat_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed vector table, a random
// transaction loop against a latency/result model, and hand-written
// sequences for throughput, spurious ACK and mid-transaction reset.
module tb_bus_initiator;

  localparam int TO = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        STB_O, WE_O, ACK_I;
  logic [31:0] ADR_O, DAT_O, DAT_I;

  // Peripheral model controls
  int          wait_n;
  int          stb_cnt;
  logic [31:0] per_dat;
  logic        force_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  // Peripheral: counts STB cycles already elapsed, ACKs (combinationally)
  // once wait_n wait cycles have passed. Read data is only valid while
  // acknowledging, so a sample at any other time picks up garbage.
  always @(posedge clk) stb_cnt <= STB_O ? stb_cnt + 1 : 0;
  assign ACK_I = force_ack | (STB_O && (stb_cnt == wait_n));
  assign DAT_I = (ACK_I && STB_O) ? per_dat : 32'hBAD0_BAD0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dat;
    int          wait_n;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stb;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a peripheral with N wait cycles answers if N < TIMEOUT;
  // otherwise the initiator gives up after exactly TIMEOUT strobe cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.wait_n < TO) begin
      r.exp_err   = 1'b0;
      r.exp_rdata = v.we ? 32'h0 : v.dat;
      r.exp_stb   = v.wait_n + 1;
      r.exp_lat   = v.wait_n + 2;
    end else begin
      r.exp_err   = 1'b1;
      r.exp_rdata = 32'h0;
      r.exp_stb   = TO;
      r.exp_lat   = TO + 1;
    end
    return r;
  endfunction

  // Runs one transaction; entered and left just after a falling edge with
  // the initiator idle.
  task automatic run_txn(input vec_t v);
    int   lat;
    int   stb_n;
    bit   done;
    bit   stable;
    check("req_ready before request", req_ready, 1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    per_dat   = v.dat;
    wait_n    = v.wait_n;
    @(negedge clk);
    // Scramble the request fields: the bus must use the latched copy.
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; stb_n = 0; done = 0; stable = 1;
    for (int k = 1; k <= 64 && !done; k++) begin
      if (STB_O) begin
        stb_n++;
        if (ADR_O !== v.addr || WE_O !== v.we || DAT_O !== v.wdata) stable = 0;
      end
      if (resp_valid) begin
        lat  = k;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("response arrived", done, 1);
    check("bus fields stable", stable, 1);
    check("resp latency", lat, v.exp_lat);
    check("stb cycles", stb_n, v.exp_stb);
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("resp_err", resp_err, v.exp_err);
    check("stb low in resp", STB_O, 0);
    check("req_ready low in resp", req_ready, 0);
    // Backpressure with a spurious ACK present: nothing may move.
    force_ack = 1'b1;
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      check("held resp_valid", resp_valid, 1);
      check("held resp_rdata", resp_rdata, v.exp_rdata);
      check("held resp_err", resp_err, v.exp_err);
      check("held req_ready", req_ready, 0);
      check("held stb", STB_O, 0);
    end
    force_ack  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid after accept", resp_valid, 0);
    check("req_ready after accept", req_ready, 1);
  endtask

  vec_t vecs [5];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, resps, stbs;
    bit prev_stb, overlap, quiet;
    logic [31:0] held;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; wait_n = NEVER; per_dat = '0; force_ack = 1'b0;

    // Reset values
    #12;
    check("rst req_ready", req_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_err", resp_err, 0);
    check("rst STB_O", STB_O, 0);
    check("rst WE_O", WE_O, 0);
    check("rst ADR_O", ADR_O, 0);
    check("rst DAT_O", DAT_O, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("req_ready after reset", req_ready, 1);

    // Directed vectors
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0, 32'h0000_002A, 0, 0, 32'h0000_002A, 1'b0, 1, 2};
    vecs[1] = '{1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0000_1234, 3, 0, 32'h0, 1'b0, 4, 5};
    vecs[2] = '{1'b0, 32'h0000_3000, 32'h0, 32'h0000_0077, NEVER, 0, 32'h0, 1'b1, 4, 5};
    vecs[3] = '{1'b0, 32'h0000_3000, 32'h0, 32'h0000_0055, 3, 1, 32'h0000_0055, 1'b0, 4, 5};
    vecs[4] = '{1'b0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 1, 5, 32'hCAFE_F00D, 1'b0, 2, 3};
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Spurious ACK in IDLE
    held = resp_rdata;
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle ack: req_ready", req_ready, 1);
    check("idle ack: stb", STB_O, 0);
    check("idle ack: resp_valid", resp_valid, 0);
    check("idle ack: rdata", resp_rdata, held);
    force_ack = 1'b0;

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      rv.we     = 1'($urandom_range(0, 1));
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.dat    = $urandom;
      rv.wait_n = $urandom_range(0, 6);
      rv.delay  = $urandom_range(0, 3);
      run_txn(model(rv));
    end

    // Back-to-back throughput: one transaction per 3 cycles, STB never
    // high on two consecutive cycles.
    wait_n = 0; per_dat = 32'h1111_2222; req_we = 1'b0; req_addr = 32'h10;
    resp_ready = 1'b1; req_valid = 1'b1;
    acc = 0; resps = 0; stbs = 0; prev_stb = 0; overlap = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc++;
      if (resp_valid) resps++;
      if (STB_O) stbs++;
      if (prev_stb && STB_O) overlap = 1;
      prev_stb = STB_O;
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    check("b2b accepts", acc, 4);
    check("b2b responses", resps, 4);
    check("b2b stb cycles", stbs, 4);
    check("b2b stb gap", overlap, 0);
    check("b2b rdata", resp_rdata, 32'h1111_2222);
    @(negedge clk);

    // Reset during the 2nd wait cycle of a transaction
    wait_n = NEVER; req_we = 1'b1; req_addr = 32'h0000_5000; req_wdata = 32'h5555_AAAA;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre-reset stb", STB_O, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async rst stb", STB_O, 0);
    check("async rst req_ready", req_ready, 0);
    check("async rst resp_valid", resp_valid, 0);
    check("async rst ADR_O", ADR_O, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (resp_valid || STB_O || !req_ready) quiet = 0;
      @(negedge clk);
    end
    check("no response after reset", quiet, 1);
    rv = '{1'b0, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 2, 1, 32'h0, 1'b0, 0, 0};
    run_txn(model(rv));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
